// File: rtl/ahb_arbiter2.sv
// Two-master AHB bus arbiter.
// Round-robin grant between two masters, parked on DEFAULT_MASTER when idle.
// Fixed-length bursts keep the bus locked to their owner until the last beat.
// An ERROR response ends the burst early.
// HMASTER trails HGRANT by one HREADY cycle, and HMASTERD trails HMASTER by
// one more, so the address and data phases are each steered correctly.
module ahb_arbiter2 #(
  parameter int unsigned DEFAULT_MASTER = 0
) (
  input  logic       HCLK,
  input  logic       HRESET,
  input  logic [1:0] HBUSREQ,
  input  logic [1:0] HTRANS,
  input  logic [2:0] HBURST,
  input  logic       HREADY,
  input  logic       HRESP,
  output logic [1:0] HGRANT,
  output logic       HMASTER,
  output logic       HMASTERD
);

  localparam logic [1:0] TR_IDLE   = 2'd0;
  localparam logic [1:0] TR_BUSY   = 2'd1;
  localparam logic [1:0] TR_NONSEQ = 2'd2;
  localparam logic [1:0] TR_SEQ    = 2'd3;

  localparam logic       DEF_IDX   = (DEFAULT_MASTER != 0);
  localparam logic [1:0] DEF_GRANT = DEF_IDX ? 2'b10 : 2'b01;

  logic [3:0] cnt;        // beats still owed in the current fixed burst
  logic       last;       // previous arbitration winner
  logic [3:0] cnt_nxt;
  logic [3:0] burst_load; // decoded length minus one
  logic       burst_fixed;
  logic       acc_nonseq;
  logic       acc_seq;
  logic       hold;
  logic       win;
  logic       any_req;

  // Decode the burst length and classify the current beat.
  always_comb begin
    burst_fixed = |HBURST[2:1];
    case (HBURST[2:1])
      2'd1:    burst_load = 4'd3;
      2'd2:    burst_load = 4'd7;
      2'd3:    burst_load = 4'd15;
      default: burst_load = 4'd0;
    endcase
    acc_nonseq = HREADY && (HTRANS == TR_NONSEQ);
    acc_seq    = HREADY && (HTRANS == TR_SEQ);
  end

  // Lock the bus while a fixed burst still has beats left.
  // An ERROR response always releases the lock.
  always_comb begin
    hold = !HRESP && ((acc_nonseq && burst_fixed) ||
                      (cnt > 4'd1) ||
                      ((cnt == 4'd1) && !acc_seq));
  end

  // Next beat count. ERROR takes priority over loading a new burst.
  always_comb begin
    cnt_nxt = cnt;
    if (HRESP) begin
      cnt_nxt = 4'd0;
    end else if (HREADY) begin
      case (HTRANS)
        TR_IDLE:   cnt_nxt = 4'd0;
        TR_NONSEQ: cnt_nxt = burst_fixed ? burst_load : 4'd0;
        TR_SEQ:    cnt_nxt = (cnt != 4'd0) ? cnt - 4'd1 : cnt;
        TR_BUSY:   cnt_nxt = cnt;
        default:   cnt_nxt = cnt;
      endcase
    end
  end

  // Pick the next owner: round-robin on contention, or park when no master requests.
  always_comb begin
    any_req = |HBUSREQ;
    case (HBUSREQ)
      2'b11:   win = ~last;
      2'b01:   win = 1'b0;
      2'b10:   win = 1'b1;
      default: win = DEF_IDX;
    endcase
  end

  // Registered grant and owner state.
  // A park grant leaves the round-robin pointer alone.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      HGRANT   <= DEF_GRANT;
      HMASTER  <= DEF_IDX;
      HMASTERD <= DEF_IDX;
      cnt      <= 4'd0;
      last     <= DEF_IDX;
    end else begin
      cnt <= cnt_nxt;
      if (HREADY) begin
        HMASTER  <= HGRANT[1];
        HMASTERD <= HMASTER;
        if (!hold) begin
          HGRANT <= win ? 2'b10 : 2'b01;
          if (any_req) last <= win;
        end
      end
    end
  end

endmodule
